// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial link (transmitter and receiver).
package serial_pkg;

  // Frame state encoding, shared with the matching receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Line levels that frame every word.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width helper: clog2 with a floor of one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the
// last cycle of each bit, i.e. the edge that forms the bit boundary.
module serial_tx_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Boundary tick; suppressed while held in clear.
  assign tick_o = !clear_i && (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Next count: restart on clear or at a bit boundary.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Divide counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB
// first, stop bit, each held CLKS_PER_BIT clocks.
// Handshake: a word transfers on a rising edge where VALID=1 and READY=1;
// VALID seen while READY=0 is ignored and D is not sampled.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  output logic             Q,
  output logic             BUSY,
  output tx_state_e        dbg_state_o
);

  localparam int BW = cnt_width(WIDTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             q_q, q_d;
  logic             ready_q, ready_d;
  logic             busy_q;
  logic             timer_clr;
  logic             tick;
  logic [WIDTH-1:0] shift_next;

  serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i   (C),
    .rst_i   (R),
    .clear_i (timer_clr),
    .tick_o  (tick)
  );

  assign shift_next  = shift_q >> 1;
  assign READY       = ready_q;
  assign BUSY        = busy_q;
  assign Q           = q_q;
  assign dbg_state_o = state_q;

  // Next-state and next-output logic; Q is computed one cycle ahead so the
  // line level is taken straight from a flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    q_d       = q_q;
    ready_d   = ready_q;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clr = 1'b1;
        if (VALID && ready_q) begin
          shift_d = D;
          state_d = START;
          q_d     = START_BIT;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
          q_d     = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_next;
          if (bit_q == BW'(WIDTH - 1)) begin
            state_d = STOP;
            q_d     = STOP_BIT;
          end else begin
            bit_d = bit_q + BW'(1);
            q_d   = shift_next[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
          q_d     = LINE_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        q_d     = LINE_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      q_q     <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance for the main
// frame behaviour and a 4-bit/1-clock instance for the no-stall corner.
module tb_serial_tx;
  import serial_pkg::*;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r8 = 1'b1, valid8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       ready8, q8, busy8;
  tx_state_e  st8;

  logic       r4 = 1'b1, valid4 = 1'b0;
  logic [3:0] d4 = 4'h0;
  logic       ready4, q4, busy4;
  tx_state_e  st4;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut8 (
    .C(clk), .R(r8), .D(d8), .VALID(valid8),
    .READY(ready8), .Q(q8), .BUSY(busy8), .dbg_state_o(st8)
  );

  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut4 (
    .C(clk), .R(r4), .D(d4), .VALID(valid4),
    .READY(ready4), .Q(q4), .BUSY(busy4), .dbg_state_o(st4)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle8(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_q"}, 32'(q8), 32'd1);
      check({tag, "_ready"}, 32'(ready8), 32'd1);
      check({tag, "_busy"}, 32'(busy8), 32'd0);
      step();
    end
  endtask

  // Called just after the accepting edge; checks all 40 cycles of the
  // frame and returns just after the edge that ends it. With noise set,
  // VALID is raised with toggling D for cycles 5..14 of the frame.
  task automatic check_frame8(input string tag, input logic [7:0] data,
                              input bit noise);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < 4; c++) begin
        if (noise) begin
          if (g * 4 + c >= 5 && g * 4 + c < 15) begin
            valid8 = 1'b1;
            d8     = ((g * 4 + c) % 2 == 0) ? 8'hFF : 8'h00;
          end else begin
            valid8 = 1'b0;
          end
        end
        check({tag, "_q"}, 32'(q8), 32'(frame[g]));
        check({tag, "_ready"}, 32'(ready8), 32'd0);
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        step();
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0] exp4;

    // Reset idle.
    step();
    step();
    r8 = 1'b0;
    r4 = 1'b0;
    check("rst_state", 32'(st8), 32'(IDLE));
    check_idle8("rst_idle", 20);

    // Single frame 8'hA5.
    d8 = 8'hA5; valid8 = 1'b1;
    step();
    valid8 = 1'b0; d8 = 8'h3C;
    check_frame8("a5", 8'hA5, 1'b0);
    check_idle8("a5_after", 3);

    // Busy ignore: VALID with toggling D during the frame.
    d8 = 8'hA5; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    check_frame8("a5_busy", 8'hA5, 1'b1);
    check_idle8("no_second", 10);

    // Back-to-back: VALID held high across two frames.
    d8 = 8'h01; valid8 = 1'b1;
    step();
    d8 = 8'h80;
    check_frame8("b2b_01", 8'h01, 1'b0);
    check("b2b_gap_q", 32'(q8), 32'd1);
    check("b2b_gap_ready", 32'(ready8), 32'd1);
    step();
    valid8 = 1'b0;
    check_frame8("b2b_80", 8'h80, 1'b0);
    check_idle8("b2b_after", 2);

    // Reset during data bit 3 of 8'h00 (frame cycles 16..19).
    d8 = 8'h00; valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("mid_pre_q", 32'(q8), 32'd0);
    check("mid_pre_state", 32'(st8), 32'(DATA));
    r8 = 1'b1;
    step();
    r8 = 1'b0;
    check("mid_state", 32'(st8), 32'(IDLE));
    check_idle8("mid_rst", 20);

    // Corner: WIDTH=4, CLKS_PER_BIT=1, D=4'hC -> 0,0,0,1,1,1.
    exp4 = 6'b111000;
    d4 = 4'hC; valid4 = 1'b1;
    check("c4_ready_pre", 32'(ready4), 32'd1);
    step();
    valid4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("c4_q", 32'(q4), 32'(exp4[i]));
      check("c4_ready", 32'(ready4), 32'd0);
      check("c4_busy", 32'(busy4), 32'd1);
      step();
    end
    check("c4_ready_post", 32'(ready4), 32'd1);
    check("c4_q_post", 32'(q4), 32'd1);
    check("c4_state_post", 32'(st4), 32'(IDLE));

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
